// File: rtl/oled_sched_pkg.sv
// ----------------------------------------------------------------------------
// oled_sched_pkg
// Shared types and constants for the OLED source scheduler.
//   - state_t  : scheduler FSM encoding (IDLE/SHOW/BLANK)
//   - cand_t   : filtered switch request {valid, source index}
//   - widths   : source count, index width, RGB565 pixel width, counter width
// ----------------------------------------------------------------------------
package oled_sched_pkg;

   localparam int unsigned NUM_SRC = 4;
   localparam int unsigned SRC_W   = 2;
   localparam int unsigned PIX_W   = 16;
   localparam int unsigned CNT_W   = 4;
   localparam int unsigned BUS_W   = NUM_SRC * PIX_W;

   localparam logic [PIX_W-1:0] COLOR_BLACK = 16'h0000;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SHOW  = 2'd1,
      ST_BLANK = 2'd2
   } state_t;

   typedef struct packed {
      logic             vld;
      logic [SRC_W-1:0] idx;
   } cand_t;

   // One-hot enable for a source index.
   function automatic logic [NUM_SRC-1:0] src_onehot(input logic [SRC_W-1:0] idx);
      return NUM_SRC'(1) << idx;
   endfunction

endpackage

// File: rtl/oled_src_scheduler_if.sv
// ----------------------------------------------------------------------------
// oled_src_scheduler_if
// Pixel-path bundle between the task generators / Oled_Display and the
// scheduler.
//   sel[3:0]         raw asynchronous source requests
//   frame_begin      one-cycle frame start pulse
//   src_data[63:0]   four RGB565 source pixels, source i at [16i+15:16i]
//   oled_data[15:0]  selected pixel to Oled_Display
//   src_en[3:0]      one-hot enable of the displayed source
//   active_src[1:0]  displayed source index
//   switching        high during blank frames
// master = stimulus side, slave = scheduler.
// ----------------------------------------------------------------------------
interface oled_src_scheduler_if;
   import oled_sched_pkg::*;

   logic [NUM_SRC-1:0] sel;
   logic               frame_begin;
   logic [BUS_W-1:0]   src_data;
   logic [PIX_W-1:0]   oled_data;
   logic [NUM_SRC-1:0] src_en;
   logic [SRC_W-1:0]   active_src;
   logic               switching;

   modport master (
      output sel, frame_begin, src_data,
      input  oled_data, src_en, active_src, switching
   );

   modport slave (
      input  sel, frame_begin, src_data,
      output oled_data, src_en, active_src, switching
   );

endinterface

// File: rtl/oled_sel_filter.sv
// ----------------------------------------------------------------------------
// oled_sel_filter
// Request conditioning for the scheduler: two-flop synchronizer on the raw
// switch requests, lowest-index-wins priority encoder, and a per-frame
// stability counter.
//   clk, rst_n       clock, async active-low reset
//   i_sel            raw asynchronous requests
//   i_frame_begin    frame start pulse
//   o_cand_c         current candidate {vld, idx} (decoded from sync flops)
//   o_stable_c       candidate has held for STABLE_FRAMES frame starts
// ----------------------------------------------------------------------------
module oled_sel_filter
   import oled_sched_pkg::*;
#(
   parameter int unsigned STABLE_FRAMES = 2
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic [NUM_SRC-1:0] i_sel,
   input  logic               i_frame_begin,
   output cand_t              o_cand_c,
   output logic               o_stable_c
);

   localparam logic [CNT_W-1:0] STAB_MAX = CNT_W'(STABLE_FRAMES);

   logic [NUM_SRC-1:0] r_sync1;
   logic [NUM_SRC-1:0] r_sync2;
   cand_t              r_prev;
   logic [CNT_W-1:0]   r_stab_cnt;
   cand_t              w_cand;

   // Synchronizer: two flops, no logic in between.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_sync1 <= '0;
         r_sync2 <= '0;
      end else begin
         r_sync1 <= i_sel;
         r_sync2 <= r_sync1;
      end
   end

   // Priority encoder: scanning downward leaves the lowest set bit as winner.
   always_comb begin
      w_cand = '0;
      for (int i = NUM_SRC - 1; i >= 0; i--) begin
         if (r_sync2[i]) begin
            w_cand.vld = 1'b1;
            w_cand.idx = SRC_W'(i);
         end
      end
   end

   // Stability counter: any candidate change restarts the count, even on a
   // frame start cycle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_prev     <= '0;
         r_stab_cnt <= '0;
      end else begin
         r_prev <= w_cand;
         if (w_cand != r_prev) begin
            r_stab_cnt <= '0;
         end else if (i_frame_begin && (r_stab_cnt != STAB_MAX)) begin
            r_stab_cnt <= r_stab_cnt + CNT_W'(1);
         end
      end
   end

   assign o_cand_c   = w_cand;
   assign o_stable_c = (r_stab_cnt == STAB_MAX);

endmodule

// File: rtl/oled_src_scheduler.sv
// ----------------------------------------------------------------------------
// oled_src_scheduler
// Frame-synchronous owner selection for the single OLED pixel stream.
// Ownership only changes on frame_begin, optionally through BLANK_FRAMES
// frames of BLANK_COLOR, so a displayed frame is never torn.
//   clk, rst_n   pixel clock, async active-low reset
//   bus (slave)  sel / frame_begin / src_data in;
//                oled_data / src_en / active_src / switching out (registered)
// ----------------------------------------------------------------------------
module oled_src_scheduler
   import oled_sched_pkg::*;
#(
   parameter int unsigned      STABLE_FRAMES = 2,
   parameter int unsigned      BLANK_FRAMES  = 1,
   parameter logic [PIX_W-1:0] IDLE_COLOR    = COLOR_BLACK,
   parameter logic [PIX_W-1:0] BLANK_COLOR   = COLOR_BLACK
) (
   input  logic                 clk,
   input  logic                 rst_n,
   oled_src_scheduler_if.slave  bus
);

   localparam logic [CNT_W-1:0] BLANK_MAX = CNT_W'(BLANK_FRAMES);

   state_t             r_state;
   logic [SRC_W-1:0]   r_active;
   logic [SRC_W-1:0]   r_next_src;
   logic [CNT_W-1:0]   r_blank_cnt;
   logic [PIX_W-1:0]   r_oled_data;
   logic [NUM_SRC-1:0] r_src_en;
   logic               r_switching;

   cand_t              w_cand;
   logic               w_stable;
   state_t             w_state_nxt;
   logic [SRC_W-1:0]   w_active_nxt;
   logic [SRC_W-1:0]   w_next_src_nxt;
   logic [CNT_W-1:0]   w_blank_cnt_nxt;
   logic [CNT_W-1:0]   w_blank_inc;
   logic [SRC_W-1:0]   w_exit_src;
   logic [PIX_W-1:0]   w_show_pix;
   logic [PIX_W-1:0]   w_pix_nxt;

   oled_sel_filter #(
      .STABLE_FRAMES (STABLE_FRAMES)
   ) u_sel_filter (
      .clk           (clk),
      .rst_n         (rst_n),
      .i_sel         (bus.sel),
      .i_frame_begin (bus.frame_begin),
      .o_cand_c      (w_cand),
      .o_stable_c    (w_stable)
   );

   // Transition decision; only frame_begin cycles can move the FSM.
   always_comb begin
      w_state_nxt     = r_state;
      w_active_nxt    = r_active;
      w_next_src_nxt  = r_next_src;
      w_blank_cnt_nxt = r_blank_cnt;
      w_blank_inc     = r_blank_cnt + CNT_W'(1);
      // A stable request seen on the exit frame overrides the queued source.
      w_exit_src      = (w_stable && w_cand.vld) ? w_cand.idx : r_next_src;

      if (bus.frame_begin) begin
         case (r_state)
            ST_IDLE: begin
               if (w_stable && w_cand.vld) begin
                  w_state_nxt  = ST_SHOW;
                  w_active_nxt = w_cand.idx;
               end
            end
            ST_SHOW: begin
               if (w_stable && !w_cand.vld) begin
                  w_state_nxt = ST_IDLE;
               end else if (w_stable && (w_cand.idx != r_active)) begin
                  if (BLANK_FRAMES == 0) begin
                     w_active_nxt = w_cand.idx;
                  end else begin
                     w_state_nxt     = ST_BLANK;
                     w_next_src_nxt  = w_cand.idx;
                     w_blank_cnt_nxt = '0;
                  end
               end
            end
            ST_BLANK: begin
               w_next_src_nxt  = w_exit_src;
               w_blank_cnt_nxt = w_blank_inc;
               if (w_blank_inc == BLANK_MAX) begin
                  if (w_stable && !w_cand.vld) begin
                     w_state_nxt = ST_IDLE;
                  end else begin
                     w_state_nxt  = ST_SHOW;
                     w_active_nxt = w_exit_src;
                  end
               end
            end
            default: begin
               w_state_nxt = ST_IDLE;
            end
         endcase
      end
   end

   // Lane select for the source that will own the next pixel.
   always_comb begin
      w_show_pix = '0;
      for (int i = 0; i < NUM_SRC; i++) begin
         if (w_active_nxt == SRC_W'(i)) begin
            w_show_pix = bus.src_data[i*PIX_W +: PIX_W];
         end
      end
   end

   // Output pixel follows the upcoming state so the first pixel of a new
   // frame already comes from the new owner.
   always_comb begin
      case (w_state_nxt)
         ST_SHOW:  w_pix_nxt = w_show_pix;
         ST_BLANK: w_pix_nxt = BLANK_COLOR;
         default:  w_pix_nxt = IDLE_COLOR;
      endcase
   end

   // State, counters and all outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= ST_IDLE;
         r_active    <= '0;
         r_next_src  <= '0;
         r_blank_cnt <= '0;
         r_oled_data <= IDLE_COLOR;
         r_src_en    <= '0;
         r_switching <= 1'b0;
      end else begin
         r_state     <= w_state_nxt;
         r_active    <= w_active_nxt;
         r_next_src  <= w_next_src_nxt;
         r_blank_cnt <= w_blank_cnt_nxt;
         r_oled_data <= w_pix_nxt;
         r_src_en    <= (w_state_nxt == ST_SHOW) ? src_onehot(w_active_nxt) : '0;
         r_switching <= (w_state_nxt == ST_BLANK);
      end
   end

   assign bus.oled_data  = r_oled_data;
   assign bus.src_en     = r_src_en;
   assign bus.active_src = r_active;
   assign bus.switching  = r_switching;

endmodule

// File: tb/tb_oled_src_scheduler.sv
// ----------------------------------------------------------------------------
// tb_oled_src_scheduler
// Self-checking bench for oled_src_scheduler: directed scenarios plus a
// randomized run, all compared against a frame-level reference model.
// ----------------------------------------------------------------------------
module tb_oled_src_scheduler;

   localparam int unsigned STABLE_FRAMES = 2;
   localparam int unsigned BLANK_FRAMES  = 1;
   localparam logic [15:0] IDLE_COLOR    = 16'h0000;
   localparam logic [15:0] BLANK_COLOR   = 16'h0000;

   localparam int MS_IDLE  = 0;
   localparam int MS_SHOW  = 1;
   localparam int MS_BLANK = 2;

   logic clk;
   logic rst_n;

   int n_checks;
   int n_fails;

   oled_src_scheduler_if bus ();

   oled_src_scheduler #(
      .STABLE_FRAMES (STABLE_FRAMES),
      .BLANK_FRAMES  (BLANK_FRAMES),
      .IDLE_COLOR    (IDLE_COLOR),
      .BLANK_COLOR   (BLANK_COLOR)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference model state: requests seen in the last two cycles, frames the
   // current request has been held, who owns the screen, and blank progress.
   logic [3:0]  m_sel_d1, m_sel_d2;
   logic        m_prev_vld;
   logic [1:0]  m_prev_idx;
   int          m_held;
   int          m_state;
   logic [1:0]  m_active;
   logic [1:0]  m_next;
   int          m_blanks;
   logic [15:0] m_pix;

   logic [63:0] last_data;
   logic        force_l0_en;
   logic [15:0] force_l0;

   task automatic model_reset();
      m_sel_d1 = '0; m_sel_d2 = '0;
      m_prev_vld = 1'b0; m_prev_idx = '0;
      m_held = 0; m_state = MS_IDLE;
      m_active = '0; m_next = '0; m_blanks = 0;
      m_pix = IDLE_COLOR;
   endtask

   function automatic logic [3:0] m_src_en();
      return (m_state == MS_SHOW) ? (4'b0001 << m_active) : 4'b0000;
   endfunction

   // Advance the model by one clock with the inputs present in that cycle.
   task automatic model_advance(input logic [3:0] s, input logic f, input logic [63:0] d);
      logic        vld;
      logic [1:0]  idx;
      logic        stable;
      logic [63:0] sh;
      vld = 1'b0; idx = 2'd0;
      for (int i = 0; i < 4; i++) begin
         if (!vld && m_sel_d2[i]) begin
            vld = 1'b1;
            idx = 2'(i);
         end
      end
      stable = (m_held == int'(STABLE_FRAMES));
      if (f) begin
         if (m_state == MS_IDLE) begin
            if (stable && vld) begin
               m_state = MS_SHOW; m_active = idx;
            end
         end else if (m_state == MS_SHOW) begin
            if (stable && !vld) m_state = MS_IDLE;
            else if (stable && idx != m_active) begin
               if (BLANK_FRAMES == 0) m_active = idx;
               else begin
                  m_state = MS_BLANK; m_next = idx; m_blanks = 0;
               end
            end
         end else begin
            if (stable && vld) m_next = idx;
            m_blanks++;
            if (m_blanks == int'(BLANK_FRAMES)) begin
               if (stable && !vld) m_state = MS_IDLE;
               else begin
                  m_state = MS_SHOW; m_active = m_next;
               end
            end
         end
      end
      if (vld != m_prev_vld || idx != m_prev_idx) m_held = 0;
      else if (f && m_held < int'(STABLE_FRAMES)) m_held++;
      m_prev_vld = vld; m_prev_idx = idx;
      m_sel_d2 = m_sel_d1; m_sel_d1 = s;
      if (m_state == MS_SHOW) begin
         sh = d >> (16 * m_active);
         m_pix = sh[15:0];
      end else if (m_state == MS_BLANK) m_pix = BLANK_COLOR;
      else m_pix = IDLE_COLOR;
   endtask

   // One clock of stimulus; entered and left at a falling edge.
   task automatic drive_cycle(input logic [3:0] s, input logic f);
      logic [63:0] d;
      d = {$urandom(), $urandom()};
      if (force_l0_en) d[15:0] = force_l0;
      last_data = d;
      bus.sel = s; bus.frame_begin = f; bus.src_data = d;
      model_advance(s, f, d);
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic run_frame(input logic [3:0] s, input int len);
      drive_cycle(s, 1'b1);
      repeat (len - 1) drive_cycle(s, 1'b0);
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      model_reset();
      bus.sel = '0; bus.frame_begin = 1'b0;
      rst_n = 1'b1;
   endtask

   task automatic test_reset();
      @(negedge clk);
      rst_n = 1'b0; bus.sel = 4'b1111; bus.frame_begin = 1'b0; bus.src_data = {$urandom(), $urandom()};
      repeat (3) @(negedge clk);
      n_checks++; if (bus.oled_data !== 16'h0000) begin n_fails++; $display("FAIL reset_oled got %h exp 0000", bus.oled_data); end
      n_checks++; if (bus.src_en !== 4'b0000) begin n_fails++; $display("FAIL reset_src_en got %b exp 0000", bus.src_en); end
      n_checks++; if (bus.switching !== 1'b0) begin n_fails++; $display("FAIL reset_switching got %b exp 0", bus.switching); end
      n_checks++; if (bus.active_src !== 2'd0) begin n_fails++; $display("FAIL reset_active got %0d exp 0", bus.active_src); end
      model_reset();
      bus.sel = 4'b0000; rst_n = 1'b1;
      repeat (5) run_frame(4'b0000, 4);
      n_checks++; if (bus.src_en !== 4'b0000 || bus.switching !== 1'b0 || bus.oled_data !== IDLE_COLOR) begin
         n_fails++; $display("FAIL idle_hold got en=%b sw=%b pix=%h exp en=0000 sw=0 pix=%h", bus.src_en, bus.switching, bus.oled_data, IDLE_COLOR);
      end
   endtask

   task automatic test_start();
      force_l0_en = 1'b1; force_l0 = 16'hF800;
      repeat (3) drive_cycle(4'b0001, 1'b0);
      for (int k = 1; k <= 3; k++) begin
         drive_cycle(4'b0001, 1'b1);
         if (k < 3) begin
            n_checks++; if (bus.src_en !== 4'b0000) begin n_fails++; $display("FAIL start_early fb%0d got en=%b exp 0000", k, bus.src_en); end
         end else begin
            n_checks++; if (bus.src_en !== 4'b0001) begin n_fails++; $display("FAIL start_en got %b exp 0001", bus.src_en); end
            n_checks++; if (bus.oled_data !== 16'hF800) begin n_fails++; $display("FAIL start_pix got %h exp F800", bus.oled_data); end
         end
         repeat (3) drive_cycle(4'b0001, 1'b0);
      end
      force_l0_en = 1'b0;
      drive_cycle(4'b0001, 1'b0);
      n_checks++; if (bus.oled_data !== last_data[15:0]) begin n_fails++; $display("FAIL start_latency got %h exp %h", bus.oled_data, last_data[15:0]); end
   endtask

   task automatic test_switch();
      logic [63:0] d;
      repeat (3) drive_cycle(4'b0100, 1'b0);
      for (int k = 1; k <= 3; k++) begin
         drive_cycle(4'b0100, 1'b1);
         if (k < 3) begin
            n_checks++; if (bus.src_en !== 4'b0001 || bus.switching !== 1'b0) begin
               n_fails++; $display("FAIL switch_hold fb%0d got en=%b sw=%b exp en=0001 sw=0", k, bus.src_en, bus.switching);
            end
         end
         if (k < 3) repeat (3) drive_cycle(4'b0100, 1'b0);
      end
      n_checks++; if (bus.switching !== 1'b1 || bus.src_en !== 4'b0000 || bus.oled_data !== BLANK_COLOR) begin
         n_fails++; $display("FAIL switch_blank_entry got sw=%b en=%b pix=%h exp sw=1 en=0000 pix=%h", bus.switching, bus.src_en, bus.oled_data, BLANK_COLOR);
      end
      for (int c = 0; c < 3; c++) begin
         drive_cycle(4'b0100, 1'b0);
         n_checks++; if (bus.switching !== 1'b1 || bus.oled_data !== BLANK_COLOR) begin
            n_fails++; $display("FAIL switch_blank_frame c%0d got sw=%b pix=%h exp sw=1 pix=%h", c, bus.switching, bus.oled_data, BLANK_COLOR);
         end
      end
      drive_cycle(4'b0100, 1'b1);
      d = last_data;
      n_checks++; if (bus.src_en !== 4'b0100 || bus.active_src !== 2'd2 || bus.switching !== 1'b0) begin
         n_fails++; $display("FAIL switch_done got en=%b act=%0d sw=%b exp en=0100 act=2 sw=0", bus.src_en, bus.active_src, bus.switching);
      end
      n_checks++; if (bus.oled_data !== d[47:32]) begin n_fails++; $display("FAIL switch_pix got %h exp %h", bus.oled_data, d[47:32]); end
   endtask

   task automatic test_priority();
      do_reset();
      repeat (3) drive_cycle(4'b0110, 1'b0);
      repeat (3) run_frame(4'b0110, 4);
      n_checks++; if (bus.active_src !== 2'd1 || bus.src_en !== 4'b0010) begin
         n_fails++; $display("FAIL priority got act=%0d en=%b exp act=1 en=0010", bus.active_src, bus.src_en);
      end
   endtask

   task automatic test_glitch();
      int bad;
      do_reset();
      repeat (3) drive_cycle(4'b0001, 1'b0);
      repeat (3) run_frame(4'b0001, 4);
      bad = 0;
      drive_cycle(4'b0010, 1'b1);
      if (bus.src_en !== 4'b0001 || bus.switching !== 1'b0) bad++;
      repeat (3) begin
         drive_cycle(4'b0010, 1'b0);
         if (bus.src_en !== 4'b0001 || bus.switching !== 1'b0) bad++;
      end
      for (int c = 0; c < 16; c++) begin
         drive_cycle(4'b0001, (c % 4) == 0);
         if (bus.src_en !== 4'b0001 || bus.switching !== 1'b0) bad++;
      end
      n_checks++; if (bad != 0) begin n_fails++; $display("FAIL glitch got %0d bad cycles exp 0", bad); end
   endtask

   task automatic test_mid_blank_reset();
      repeat (3) drive_cycle(4'b0100, 1'b0);
      repeat (3) run_frame(4'b0100, 4);
      n_checks++; if (bus.switching !== 1'b1) begin n_fails++; $display("FAIL midrst_in_blank got sw=%b exp 1", bus.switching); end
      #2 rst_n = 1'b0;
      #1;
      n_checks++; if (bus.oled_data !== IDLE_COLOR || bus.switching !== 1'b0 || bus.src_en !== 4'b0000 || bus.active_src !== 2'd0) begin
         n_fails++; $display("FAIL midrst got pix=%h sw=%b en=%b act=%0d exp pix=%h sw=0 en=0000 act=0", bus.oled_data, bus.switching, bus.src_en, bus.active_src, IDLE_COLOR);
      end
      @(negedge clk);
      model_reset();
      bus.sel = '0; bus.frame_begin = 1'b0;
      rst_n = 1'b1;
      run_frame(4'b0100, 4);
      n_checks++; if (bus.src_en !== 4'b0000 || bus.switching !== 1'b0) begin
         n_fails++; $display("FAIL midrst_after got en=%b sw=%b exp en=0000 sw=0", bus.src_en, bus.switching);
      end
   endtask

   task automatic test_random();
      logic [3:0] s;
      int len, chg_at, cyc;
      s = 4'b0000; cyc = 0;
      for (int fr = 0; fr < 200; fr++) begin
         len = $urandom_range(3, 6);
         chg_at = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, len - 1)) : -1;
         for (int c = 0; c < len; c++) begin
            if (c == chg_at) s = 4'($urandom_range(0, 15));
            drive_cycle(s, c == 0);
            cyc++;
            n_checks++; if (bus.oled_data !== m_pix) begin n_fails++; $display("FAIL rand_pix cyc %0d got %h exp %h", cyc, bus.oled_data, m_pix); end
            n_checks++; if (bus.src_en !== m_src_en()) begin n_fails++; $display("FAIL rand_en cyc %0d got %b exp %b", cyc, bus.src_en, m_src_en()); end
            n_checks++; if (bus.active_src !== m_active) begin n_fails++; $display("FAIL rand_act cyc %0d got %0d exp %0d", cyc, bus.active_src, m_active); end
            n_checks++; if (bus.switching !== (m_state == MS_BLANK)) begin n_fails++; $display("FAIL rand_sw cyc %0d got %b exp %b", cyc, bus.switching, m_state == MS_BLANK); end
         end
      end
   endtask

   initial begin
      n_checks = 0; n_fails = 0;
      force_l0_en = 1'b0; force_l0 = '0; last_data = '0;
      rst_n = 1'b0;
      bus.sel = '0; bus.frame_begin = 1'b0; bus.src_data = '0;
      model_reset();
      test_reset();
      test_start();
      test_switch();
      test_priority();
      test_glitch();
      test_mid_blank_reset();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog expired after 500000 time units");
      $fatal(1);
   end

endmodule
